serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  operand A; captured when start is accepted.
REQ-006 Port: B  input  WIDTH  operand B; captured when start is accepted.
REQ-007 Port: Cin  input  1  initial carry-in; captured when start is accepted.
REQ-008 Port: busy  output  1  high in RUN and DONE states.
REQ-009 Port: done  output  1  one-cycle pulse; sum and Cout valid while high.
REQ-010 Port: sum  output  WIDTH  result register.
REQ-011 Port: Cout  output  1  final carry-out register.

Function
REQ-012 FSM states: IDLE, RUN, DONE; one state per clock cycle, encoded from the shared package.
REQ-013 IDLE: start=1 → load A, B and Cin into the operand shift registers and carry flop, clear the bit counter, go to RUN; start=0 → stay in IDLE.
REQ-014 RUN: each cycle feed bit 0 of the A and B shift registers plus the carry flop into one full-adder cell; shift the cell's sum bit into sum MSB-first (right shift), store the cell's carry in the carry flop, shift the operands right by one, increment the counter.
REQ-015 RUN → DONE on the edge that processes bit WIDTH-1 (counter = WIDTH-1); exactly WIDTH RUN cycles, LSB first.
REQ-016 DONE: done=1 for exactly one cycle, Cout = carry flop, sum = full result; next edge → IDLE unconditionally.
REQ-017 Latency: start sampled at edge k → done high during cycle k+WIDTH+1.
REQ-018 start in RUN or DONE is ignored; no queuing, no abort, and operands are not reloaded.
REQ-019 A, B and Cin changing after acceptance has no effect on the result.
REQ-020 sum and Cout hold their last result through IDLE until the next accepted start; sum changes bit by bit during RUN.
REQ-021 Arithmetic: {Cout, sum} = A + B + Cin, modulo 2^(WIDTH+1); overflow is carried only in Cout.
REQ-022 Back-to-back: start held high continuously → a new operation is accepted in the IDLE cycle after each DONE, giving a period of WIDTH+2 cycles.

Reset
REQ-023 rst=1 at a rising edge → state=IDLE, busy=0, done=0, sum=0, Cout=0, counter=0, carry flop=0, operand registers=0.
REQ-024 rst takes priority over start and over every state, including mid-RUN and DONE; the aborted operation produces no done pulse.
REQ-025 First start is accepted at the first edge with rst=0 and start=1.

Structure
REQ-026 Shared package serial_adder_pkg holds the state typedef (IDLE, RUN, DONE), the default WIDTH constant and the counter-width function clog2(WIDTH).
REQ-027 One sub-module: the existing single-bit combinational full-adder cell (ports A, B, Cin, out, Cout), instantiated once; no other arithmetic operators are permitted in the datapath.
REQ-028 All outputs are registered; there is no combinational path from any input to any output.

Verification
REQ-029 WIDTH=8, rst=1 for 2 cycles, then release → busy=0, done=0, sum=0x00, Cout=0.
REQ-030 A=0x35, B=0x4A, Cin=0, start pulse at edge k → done high in cycle k+9 only; sum=0x7F, Cout=0.
REQ-031 A=0xFF, B=0x01, Cin=1 → sum=0x01, Cout=1 (full carry ripple across all bits).
REQ-032 A=0x10, B=0x20 accepted; start re-pulsed with A=0xFF, B=0xFF during RUN → result sum=0x30, Cout=0; no second done pulse.
REQ-033 rst asserted at the 4th RUN cycle of an A=0xAA, B=0x55 operation → IDLE on the next edge, sum=0x00, Cout=0, no done pulse.
REQ-034 start held high, operands 0x01+0x01 and then 0x80+0x80 → done pulses 10 cycles apart; results 0x02/0 and then 0x00/1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder controller.
// Contents:
//   WIDTH_DEFAULT : default operand width
//   state_t       : controller states IDLE / RUN / DONE
//   clog2()       : bit counter width for a given operand width
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest n with 2**n >= value; the counter only has to reach WIDTH-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit combinational full-adder cell.
// Ports:
//   A, B, Cin : input bits
//   out       : sum bit
//   Cout      : carry-out bit
module serial_adder_ctrl_fa
  import serial_adder_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic out,
  output logic Cout
);

  assign out  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus a carry-in,
// one bit per clock, LSB first, through a single full-adder cell.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin an addition (honoured only when idle)
//   A, B, Cin    : operands and carry-in, captured on acceptance
//   busy         : high while an addition is running or completing
//   done         : one-cycle pulse, sum/Cout valid while high
//   sum, Cout    : result registers, held until the next accepted start
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             Cout
);

  localparam int            CW       = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             last_bit_s;
  logic             fa_sum_s;
  logic             fa_cout_s;

  serial_adder_ctrl_fa u_fa (
    .A    (a_r[0]),
    .B    (b_r[0]),
    .Cin  (carry_r),
    .out  (fa_sum_s),
    .Cout (fa_cout_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; last_bit_s flags the RUN cycle that handles the MSB
  always_comb begin
    state_next_s = state_r;
    last_bit_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        last_bit_s = (count_r == LAST_BIT);
        if (last_bit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Operand capture, serial datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      count_r <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= A;
            b_r     <= B;
            carry_r <= Cin;
            count_r <= '0;
          end
        end
        RUN: begin
          a_r     <= {1'b0, a_r[WIDTH-1:1]};
          b_r     <= {1'b0, b_r[WIDTH-1:1]};
          carry_r <= fa_cout_s;
          // New bit enters at the MSB; after WIDTH shifts bit 0 is at the LSB.
          sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
          count_r <= count_r + CW'(1);
          if (last_bit_s) begin
            cout_r <= fa_cout_s;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
      // Status flags follow the state being entered so they stay registered.
      busy_r <= (state_next_s != IDLE);
      done_r <= (state_next_s == DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign Cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed scenarios with
// literal expectations plus randomized traffic compared every cycle against an
// arithmetic model of the operation timeline.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         Cout;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .Cout  (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation occupies edges t=1..W+1 after
  // acceptance; the result A+B+Cin appears with done at t=W.
  bit           m_active = 1'b0;
  int           m_t      = 0;
  logic [W:0]   m_res    = '0;
  logic         m_busy   = 1'b0;
  logic         m_done   = 1'b0;
  logic [W-1:0] m_sum    = '0;
  logic         m_cout   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_sum    = '0;
      m_cout   = 1'b0;
    end else if (!m_active) begin
      m_done = 1'b0;
      if (start) begin
        m_active = 1'b1;
        m_t      = 0;
        m_res    = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};
        m_busy   = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      m_t++;
      if (m_t == W) begin
        m_done = 1'b1;
        m_sum  = m_res[W-1:0];
        m_cout = m_res[W];
      end else if (m_t == W + 1) begin
        m_active = 1'b0;
        m_busy   = 1'b0;
        m_done   = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model; sum is only defined outside RUN
  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("done", {31'd0, done}, {31'd0, m_done});
    if (!m_busy || m_done) begin
      check("sum", {24'd0, sum}, {24'd0, m_sum});
      check("cout", {31'd0, Cout}, {31'd0, m_cout});
    end
    if (done) done_cnt++;
  end

  // Waits for done; n is the number of negedges waited, -1 on timeout
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40 && n < 0; i++) begin
      @(negedge clk);
      if (done) n = i;
    end
    if (n < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Pulses start with the given operands, then scrambles the inputs
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output int lat);
    A = a; B = b; Cin = c; start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
      if (done) lat = i;
    end
    if (lat < 0) check("op_timeout", 32'd0, 32'd1);
  endtask

  int lat;
  int d0;
  int c1;
  int c2;
  int cyc;

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {24'd0, sum},  32'h00);
    check("rst_cout", {31'd0, Cout}, 32'd0);

    // 0x35 + 0x4A: done exactly W+1 cycles after the accepting edge
    do_op(8'h35, 8'h4A, 1'b0, lat);
    check("lat_035", lat, 32'd9);
    check("sum_035", {24'd0, sum}, 32'h7F);
    check("cout_035", {31'd0, Cout}, 32'd0);
    @(negedge clk);
    check("done_pulse_width", {31'd0, done}, 32'd0);
    check("hold_sum_035", {24'd0, sum}, 32'h7F);

    // Full carry ripple
    @(negedge clk);
    do_op(8'hFF, 8'h01, 1'b1, lat);
    check("sum_ripple", {24'd0, sum}, 32'h01);
    check("cout_ripple", {31'd0, Cout}, 32'd1);
    repeat (2) @(negedge clk);

    // Start re-pulsed during RUN must be ignored
    d0 = done_cnt;
    A = 8'h10; B = 8'h20; Cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(lat);
    check("sum_ignore", {24'd0, sum}, 32'h30);
    check("cout_ignore", {31'd0, Cout}, 32'd0);
    repeat (15) @(negedge clk);
    check("single_done", done_cnt - d0, 32'd1);

    // Reset during the 4th RUN cycle aborts without a done pulse
    d0 = done_cnt;
    A = 8'hAA; B = 8'h55; Cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'h00);
    check("abort_cout", {31'd0, Cout}, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);

    // Back-to-back with start held high
    A = 8'h01; B = 8'h01; Cin = 1'b0; start = 1'b1;
    c1 = -1; c2 = -1;
    for (int i = 1; i <= 40 && c2 < 0; i++) begin
      @(negedge clk);
      if (done) begin
        if (c1 < 0) begin
          c1 = i;
          check("b2b_sum1", {24'd0, sum}, 32'h02);
          check("b2b_cout1", {31'd0, Cout}, 32'd0);
          A = 8'h80; B = 8'h80;
        end else begin
          c2 = i;
          check("b2b_sum2", {24'd0, sum}, 32'h00);
          check("b2b_cout2", {31'd0, Cout}, 32'd1);
        end
      end
    end
    start = 1'b0;
    check("b2b_period", c2 - c1, 32'd10);
    repeat (3) @(negedge clk);

    // Randomized traffic: start, operands and occasional reset every cycle
    for (cyc = 0; cyc < 800; cyc++) begin
      start = 1'($urandom);
      A     = W'($urandom);
      B     = W'($urandom);
      Cin   = 1'($urandom);
      rst   = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (15) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
